sd_block_reader: RTL and testbench

Command sequencer that sits directly upstream of the byte-level SPI master. It drives the master's register-write interface to issue an SD CMD17 (single-block read), then polls for R1 and the data token. It streams the 512 data bytes out over a valid/ready byte interface to the consumer (boot loader / RAM filler). Pacing is self-timed: each SPI byte is one write strobe followed by a fixed wait before `spi_dout` is sampled.

---
 rtl/sd_block_reader.sv | 223 ++++++++++++++++++++++
 tb/tb_sd_block_reader.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_reader.sv
// CMD17 single-block read sequencer feeding a byte-level SPI master's register interface.
// Polls for R1 and the data token, then streams 512 bytes over valid/ready.
module sd_block_reader #(
   parameter int unsigned BYTE_CYCLES = 18,
   parameter int unsigned R1_TRIES    = 8,
   parameter int unsigned TOKEN_TRIES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] block_addr,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        spi_enable,
   output logic        spi_rnw,
   output logic [2:0]  spi_addr,
   output logic [7:0]  spi_din,
   input  logic [7:0]  spi_dout,
   input  logic        spi_ready
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WAIT_RDY = 4'd1;
   localparam logic [3:0] S_CS_LO    = 4'd2;
   localparam logic [3:0] S_CMD      = 4'd3;
   localparam logic [3:0] S_R1       = 4'd4;
   localparam logic [3:0] S_TOKEN    = 4'd5;
   localparam logic [3:0] S_DATA     = 4'd6;
   localparam logic [3:0] S_CRC      = 4'd7;
   localparam logic [3:0] S_CS_HI    = 4'd8;
   localparam logic [3:0] S_TRAIL    = 4'd9;
   localparam logic [3:0] S_FIN      = 4'd10;

   localparam int unsigned MAXT = (R1_TRIES > TOKEN_TRIES) ? R1_TRIES : TOKEN_TRIES;
   localparam int unsigned TW   = $clog2(MAXT + 1);
   localparam int unsigned CW   = $clog2(BYTE_CYCLES + 1);

   logic [3:0]    state;
   logic [31:0]   addr_q;
   logic          pending;
   logic [CW-1:0] cnt;
   logic [2:0]    cmd_idx;
   logic [TW-1:0] tries;
   logic [9:0]    byte_cnt;
   logic          crc_idx;

   logic          byte_state;
   logic          cs_state;
   logic          issue;
   logic          byte_done;
   logic          cs_done;
   logic [2:0]    issue_addr;
   logic [7:0]    cmd_byte;
   logic [7:0]    issue_din;

   assign busy    = (state != S_IDLE);
   assign done    = (state == S_FIN);
   assign spi_rnw = 1'b0;

   // pending covers the strobe cycle through the sample (bytes) or the idle cycle (CS)
   always_comb begin
      byte_state = (state == S_CMD) || (state == S_R1) || (state == S_TOKEN) ||
                   (state == S_DATA) || (state == S_CRC) || (state == S_TRAIL);
      cs_state   = (state == S_CS_LO) || (state == S_CS_HI);
      issue      = !pending && (cs_state || (byte_state && !out_valid));
      byte_done  = pending && byte_state && (cnt == CW'(BYTE_CYCLES));
      cs_done    = pending && cs_state && (cnt == CW'(1));
      case (state)
         S_CMD:   issue_addr = 3'd0;
         S_CS_LO: issue_addr = 3'd4;
         S_CS_HI: issue_addr = 3'd3;
         default: issue_addr = 3'd1;
      endcase
      case (cmd_idx)
         3'd0:    cmd_byte = 8'h51;
         3'd1:    cmd_byte = addr_q[31:24];
         3'd2:    cmd_byte = addr_q[23:16];
         3'd3:    cmd_byte = addr_q[15:8];
         3'd4:    cmd_byte = addr_q[7:0];
         default: cmd_byte = 8'hFF;
      endcase
      issue_din = (state == S_CMD) ? cmd_byte : 8'hFF;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         addr_q     <= '0;
         pending    <= 1'b0;
         cnt        <= '0;
         cmd_idx    <= '0;
         tries      <= '0;
         byte_cnt   <= '0;
         crc_idx    <= 1'b0;
         error      <= 1'b0;
         err_code   <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         spi_enable <= 1'b0;
         spi_addr   <= '0;
         spi_din    <= '0;
      end else begin
         spi_enable <= 1'b0;
         if (issue) begin
            spi_enable <= 1'b1;
            spi_addr   <= issue_addr;
            spi_din    <= issue_din;
            pending    <= 1'b1;
            cnt        <= '0;
         end else if (pending) begin
            cnt <= cnt + CW'(1);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_q   <= block_addr;
                  error    <= 1'b0;
                  err_code <= '0;
                  state    <= spi_ready ? S_CS_LO : S_WAIT_RDY;
               end
            end
            S_WAIT_RDY: begin
               if (spi_ready) state <= S_CS_LO;
            end
            S_CS_LO: begin
               if (cs_done) begin
                  pending <= 1'b0;
                  cmd_idx <= '0;
                  state   <= S_CMD;
               end
            end
            S_CMD: begin
               if (byte_done) begin
                  pending <= 1'b0;
                  if (cmd_idx == 3'd5) begin
                     tries <= '0;
                     state <= S_R1;
                  end else begin
                     cmd_idx <= cmd_idx + 3'd1;
                  end
               end
            end
            S_R1: begin
               if (byte_done) begin
                  pending <= 1'b0;
                  tries   <= tries + TW'(1);
                  if (spi_dout == 8'h00) begin
                     tries <= '0;
                     state <= S_TOKEN;
                  end else if (spi_dout != 8'hFF) begin
                     err_code <= 2'd2;
                     state    <= S_CS_HI;
                  end else if (tries == TW'(R1_TRIES - 1)) begin
                     err_code <= 2'd1;
                     state    <= S_CS_HI;
                  end
               end
            end
            S_TOKEN: begin
               if (byte_done) begin
                  pending <= 1'b0;
                  tries   <= tries + TW'(1);
                  if (spi_dout == 8'hFE) begin
                     byte_cnt <= '0;
                     state    <= S_DATA;
                  end else if (spi_dout != 8'hFF || tries == TW'(TOKEN_TRIES - 1)) begin
                     err_code <= 2'd3;
                     state    <= S_CS_HI;
                  end
               end
            end
            S_DATA: begin
               // out_valid blocks the next strobe, so a stalled consumer idles the SPI clock
               if (byte_done) begin
                  pending   <= 1'b0;
                  out_data  <= spi_dout;
                  out_valid <= 1'b1;
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  byte_cnt  <= byte_cnt + 10'd1;
                  if (byte_cnt == 10'd511) begin
                     crc_idx <= 1'b0;
                     state   <= S_CRC;
                  end
               end
            end
            S_CRC: begin
               if (byte_done) begin
                  pending <= 1'b0;
                  crc_idx <= 1'b1;
                  if (crc_idx) state <= S_CS_HI;
               end
            end
            S_CS_HI: begin
               if (cs_done) begin
                  pending <= 1'b0;
                  state   <= S_TRAIL;
               end
            end
            S_TRAIL: begin
               if (byte_done) begin
                  pending <= 1'b0;
                  error   <= (err_code != 2'd0);
                  state   <= S_FIN;
               end
            end
            S_FIN: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: SD card / SPI master behavioural model plus a
// scenario-level reference of the expected strobe log, data stream and error code.
module tb_sd_block_reader;

   localparam int unsigned BC  = 18;
   localparam int unsigned R1T = 8;
   localparam int unsigned TKT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] block_addr = '0;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        spi_enable, spi_rnw;
   logic [2:0]  spi_addr;
   logic [7:0]  spi_din;
   logic [7:0]  spi_dout = 8'hFF;
   logic        spi_ready = 1'b1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   sd_block_reader #(.BYTE_CYCLES(BC), .R1_TRIES(R1T), .TOKEN_TRIES(TKT)) dut (
      .clk(clk), .reset(reset), .start(start), .block_addr(block_addr),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .spi_enable(spi_enable), .spi_rnw(spi_rnw), .spi_addr(spi_addr),
      .spi_din(spi_din), .spi_dout(spi_dout), .spi_ready(spi_ready)
   );

   always #5 clk = ~clk;

   // card script: responses to successive 0xFF poll bytes; 0xFF once exhausted
   logic [7:0]  script[$];
   logic [7:0]  resp_q[$];
   logic [15:0] log_q[$];
   logic [7:0]  rx_q[$];
   logic [15:0] exp_log[$];
   logic [7:0]  exp_data[$];
   logic [1:0]  exp_err;

   int          cyc = 0;
   int          cd = 0;
   logic [7:0]  resp_hold = 8'hFF;
   int          last_strobe = -100;
   int          last_byte_strobe = -100;
   int unsigned ready_mode = 0;
   int unsigned viol_gap = 0, viol_valid = 0, viol_stable = 0, viol_rnw = 0, viol_busy = 0;
   int unsigned done_cnt = 0, valid_rises = 0;
   logic        prev_stall = 1'b0, prev_valid = 1'b0;
   logic [7:0]  prev_data = '0;

   // master/card model and bus monitor, all on the falling edge
   always @(negedge clk) begin
      cyc++;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((cyc / 7) % 2) == 0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cd > 0) begin
         cd--;
         if (cd == 0) spi_dout = resp_hold;
      end
      if (reset) begin
         prev_stall = 1'b0;
         prev_valid = 1'b0;
         cd = 0;
         last_strobe = -100;
         last_byte_strobe = -100;
      end else begin
         if (prev_stall && (!out_valid || out_data !== prev_data)) viol_stable++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (out_valid && !prev_valid) valid_rises++;
         prev_valid = out_valid;
         if (out_valid && out_ready) rx_q.push_back(out_data);
         if (done) done_cnt++;
         if (spi_enable) begin
            if (spi_rnw !== 1'b0) viol_rnw++;
            if (out_valid) viol_valid++;
            if (cyc < last_strobe + 2 || cyc < last_byte_strobe + int'(BC) + 1) viol_gap++;
            last_strobe = cyc;
            if (spi_addr == 3'd0 || spi_addr == 3'd1) begin
               last_byte_strobe = cyc;
               resp_hold = 8'hFF;
               if (spi_addr == 3'd1 && resp_q.size() > 0) resp_hold = resp_q.pop_front();
               cd = int'(BC);
               spi_dout = 8'($urandom);
            end
            log_q.push_back({5'b0, spi_addr, (spi_addr == 3'd0) ? spi_din : 8'h00});
         end
      end
   end

   // Expected transaction list from the card script: CS low, 6 command bytes,
   // R1 polls, token polls, 512 data + 2 CRC bytes, CS high, one trailing byte.
   task automatic build_expect(input logic [31:0] a);
      int unsigned idx;
      logic [7:0]  v;
      logic [7:0]  cmd[6];
      bit          ok;
      idx = 0;
      v = 8'hFF;
      exp_log.delete();
      exp_data.delete();
      exp_err = 2'd0;
      cmd = '{8'h51, a[31:24], a[23:16], a[15:8], a[7:0], 8'hFF};
      exp_log.push_back({5'b0, 3'd4, 8'h00});
      for (int k = 0; k < 6; k++) exp_log.push_back({5'b0, 3'd0, cmd[k]});
      ok = 1'b0;
      for (int k = 0; k < int'(R1T); k++) begin
         exp_log.push_back({5'b0, 3'd1, 8'h00});
         v = (idx < script.size()) ? script[idx] : 8'hFF;
         idx++;
         if (v != 8'hFF) begin ok = 1'b1; break; end
      end
      if (!ok) exp_err = 2'd1;
      else if (v != 8'h00) exp_err = 2'd2;
      else begin
         ok = 1'b0;
         for (int k = 0; k < int'(TKT); k++) begin
            exp_log.push_back({5'b0, 3'd1, 8'h00});
            v = (idx < script.size()) ? script[idx] : 8'hFF;
            idx++;
            if (v != 8'hFF) begin ok = 1'b1; break; end
         end
         if (!ok || v != 8'hFE) exp_err = 2'd3;
         else begin
            for (int k = 0; k < 514; k++) begin
               exp_log.push_back({5'b0, 3'd1, 8'h00});
               v = (idx < script.size()) ? script[idx] : 8'hFF;
               idx++;
               if (k < 512) exp_data.push_back(v);
            end
         end
      end
      exp_log.push_back({5'b0, 3'd3, 8'h00});
      exp_log.push_back({5'b0, 3'd1, 8'h00});
   endtask

   function automatic int unsigned log_diffs();
      int unsigned n;
      n = (log_q.size() != exp_log.size()) ? 1 : 0;
      for (int i = 0; i < log_q.size() && i < exp_log.size(); i++)
         if (log_q[i] !== exp_log[i]) n++;
      return n;
   endfunction

   function automatic int unsigned data_diffs();
      int unsigned n;
      n = (rx_q.size() != exp_data.size()) ? 1 : 0;
      for (int i = 0; i < rx_q.size() && i < exp_data.size(); i++)
         if (rx_q[i] !== exp_data[i]) n++;
      return n;
   endfunction

   function automatic int unsigned viol_total();
      return viol_gap + viol_valid + viol_stable + viol_rnw + viol_busy;
   endfunction

   task automatic start_op(input logic [31:0] a);
      @(negedge clk);
      resp_q = script;
      log_q.delete();
      rx_q.delete();
      viol_gap = 0; viol_valid = 0; viol_stable = 0; viol_rnw = 0; viol_busy = 0;
      done_cnt = 0; valid_rises = 0;
      block_addr = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      block_addr = $urandom;
   endtask

   task automatic wait_done(input int limit, input int stray_at, output bit to,
                            output logic e, output logic [1:0] c, output logic b);
      to = 1'b1; e = 1'bx; c = 2'bxx; b = 1'bx;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         start = (i == stray_at);
         if (i == stray_at) block_addr = $urandom;
         if (done) begin
            e = error;
            c = err_code;
            to = 1'b0;
            @(negedge clk);
            b = busy;
            break;
         end
         if (!busy) viol_busy++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, error, out_valid, spi_enable, err_code, out_data, spi_addr, spi_din} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {busy, done, error, out_valid, spi_enable, err_code, out_data, spi_addr, spi_din});
      end
      checks++;
      if (spi_rnw !== 1'b0) begin errors++; $display("FAIL reset_rnw: got %b required 0", spi_rnw); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_read();
      bit to; logic e, b; logic [1:0] c; logic [47:0] cmdv;
      script.delete();
      script = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFE};
      for (int i = 0; i < 514; i++) script.push_back(8'(i));
      build_expect(32'h0000_0800);
      ready_mode = 0;
      start_op(32'h0000_0800);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b required 1", busy); end
      wait_done(30000, -1, to, e, c, b);
      cmdv = {log_q[1][7:0], log_q[2][7:0], log_q[3][7:0], log_q[4][7:0], log_q[5][7:0], log_q[6][7:0]};
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got timeout required done"); end
      checks++;
      if (cmdv !== 48'h51_00_00_08_00_FF) begin errors++; $display("FAIL basic_cmd: got %h required 510000080 0FF", cmdv); end
      checks++;
      if (log_diffs() !== 0) begin errors++; $display("FAIL basic_log: got %0d diffs (%0d entries) required 0 (%0d)", log_diffs(), log_q.size(), exp_log.size()); end
      checks++;
      if (data_diffs() !== 0) begin errors++; $display("FAIL basic_data: got %0d diffs (%0d bytes) required 0 (512)", data_diffs(), rx_q.size()); end
      checks++;
      if ({e, c} !== 3'b000) begin errors++; $display("FAIL basic_error: got %b/%0d required 0/0", e, c); end
      checks++;
      if (done_cnt !== 1 || b !== 1'b0) begin errors++; $display("FAIL basic_done: got %0d pulses busy_after=%b required 1/0", done_cnt, b); end
      checks++;
      if (viol_total() !== 0) begin errors++; $display("FAIL basic_protocol: got %0d violations required 0", viol_total()); end
   endtask

   task automatic test_backpressure();
      bit to; logic e, b; logic [1:0] c;
      script.delete();
      script = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFE};
      for (int i = 0; i < 514; i++) script.push_back(8'(i));
      build_expect(32'h0000_0800);
      ready_mode = 1;
      start_op(32'h0000_0800);
      wait_done(40000, -1, to, e, c, b);
      ready_mode = 0;
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got timeout required done"); end
      checks++;
      if (data_diffs() !== 0) begin errors++; $display("FAIL bp_data: got %0d diffs (%0d bytes) required 0", data_diffs(), rx_q.size()); end
      checks++;
      if (log_diffs() !== 0) begin errors++; $display("FAIL bp_log: got %0d diffs required 0", log_diffs()); end
      checks++;
      if (viol_valid !== 0 || viol_stable !== 0) begin errors++; $display("FAIL bp_stall: got %0d strobes in valid, %0d unstable required 0/0", viol_valid, viol_stable); end
      checks++;
      if ({e, c} !== 3'b000 || done_cnt !== 1) begin errors++; $display("FAIL bp_done: got err %b/%0d pulses %0d required 0/0/1", e, c, done_cnt); end
   endtask

   task automatic test_r1_timeout();
      bit to; logic e, b; logic [1:0] c; int unsigned polls;
      script.delete();
      build_expect(32'h1234_5678);
      start_op(32'h1234_5678);
      wait_done(2000, -1, to, e, c, b);
      polls = 0;
      foreach (log_q[i]) if (log_q[i][10:8] == 3'd1) polls++;
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL r1to_timeout: got timeout required done"); end
      checks++;
      if (polls !== 9) begin errors++; $display("FAIL r1to_polls: got %0d poll bytes required 9 (8 + trailing)", polls); end
      checks++;
      if (log_diffs() !== 0) begin errors++; $display("FAIL r1to_log: got %0d diffs required 0", log_diffs()); end
      checks++;
      if ({e, c} !== 3'b101) begin errors++; $display("FAIL r1to_error: got %b/%0d required 1/1", e, c); end
      repeat (10) @(negedge clk);
      checks++;
      if ({error, err_code} !== 3'b101 || done !== 1'b0) begin errors++; $display("FAIL r1to_hold: got %b/%0d done=%b required 1/1 done=0", error, err_code, done); end
   endtask

   task automatic test_r1_error();
      bit to; logic e, b; logic [1:0] c;
      script.delete();
      script = '{8'hFF, 8'h05, 8'h00, 8'hFE};
      build_expect(32'hA5A5_0001);
      start_op(32'hA5A5_0001);
      wait_done(2000, -1, to, e, c, b);
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL r1err_timeout: got timeout required done"); end
      checks++;
      if (log_q.size() !== 11) begin errors++; $display("FAIL r1err_count: got %0d strobes required 11", log_q.size()); end
      checks++;
      if (log_diffs() !== 0) begin errors++; $display("FAIL r1err_log: got %0d diffs required 0", log_diffs()); end
      checks++;
      if ({e, c} !== 3'b110) begin errors++; $display("FAIL r1err_error: got %b/%0d required 1/2", e, c); end
   endtask

   task automatic test_bad_token();
      bit to; logic e, b; logic [1:0] c;
      script.delete();
      script = '{8'h00, 8'hFF, 8'h0B, 8'hFE, 8'h11};
      build_expect(32'h0000_0001);
      start_op(32'h0000_0001);
      wait_done(2000, -1, to, e, c, b);
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL badtok_timeout: got timeout required done"); end
      checks++;
      if ({e, c} !== 3'b111) begin errors++; $display("FAIL badtok_error: got %b/%0d required 1/3", e, c); end
      checks++;
      if (valid_rises !== 0) begin errors++; $display("FAIL badtok_valid: got %0d out_valid pulses required 0", valid_rises); end
      checks++;
      if (log_diffs() !== 0) begin errors++; $display("FAIL badtok_log: got %0d diffs required 0", log_diffs()); end
   endtask

   task automatic test_token_timeout();
      bit to; logic e, b; logic [1:0] c;
      script.delete();
      script = '{8'h00};
      build_expect(32'hFFFF_FFFF);
      start_op(32'hFFFF_FFFF);
      wait_done(3000, -1, to, e, c, b);
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL toktime_timeout: got timeout required done"); end
      checks++;
      if ({e, c} !== 3'b111) begin errors++; $display("FAIL toktime_error: got %b/%0d required 1/3", e, c); end
      checks++;
      if (log_q.size() !== 7 + 1 + TKT + 2) begin errors++; $display("FAIL toktime_count: got %0d strobes required %0d", log_q.size(), 7 + 1 + TKT + 2); end
   endtask

   task automatic test_random_fail();
      bit to; logic e, b; logic [1:0] c; logic [31:0] a; int unsigned kind;
      for (int n = 0; n < 8; n++) begin
         kind = n % 4;
         a = $urandom;
         script.delete();
         if (kind == 3) begin
            for (int i = 0; i < int'(R1T); i++) script.push_back(8'hFF);
            script.push_back(8'h00);
         end else begin
            for (int i = 0; i < int'($urandom_range(0, R1T - 1)); i++) script.push_back(8'hFF);
            if (kind == 0) script.push_back(8'($urandom_range(1, 254)));
            else begin
               script.push_back(8'h00);
               if (kind == 1) begin
                  for (int i = 0; i < int'($urandom_range(0, TKT - 1)); i++) script.push_back(8'hFF);
                  script.push_back(8'($urandom_range(0, 253)));
               end
            end
         end
         build_expect(a);
         start_op(a);
         wait_done(3000, -1, to, e, c, b);
         checks++;
         if (to !== 1'b0) begin errors++; $display("FAIL rfail_timeout: kind %0d got timeout required done", kind); end
         checks++;
         if (c !== exp_err || e !== 1'b1) begin errors++; $display("FAIL rfail_error: kind %0d got %b/%0d required 1/%0d", kind, e, c, exp_err); end
         checks++;
         if (log_diffs() !== 0 || valid_rises !== 0) begin errors++; $display("FAIL rfail_log: kind %0d got %0d diffs %0d valids required 0/0", kind, log_diffs(), valid_rises); end
         checks++;
         if (done_cnt !== 1 || b !== 1'b0 || viol_total() !== 0) begin errors++; $display("FAIL rfail_done: kind %0d got %0d pulses busy_after=%b viol=%0d required 1/0/0", kind, done_cnt, b, viol_total()); end
      end
   endtask

   task automatic test_random_read();
      bit to; logic e, b; logic [1:0] c; logic [31:0] a;
      a = $urandom;
      script.delete();
      for (int i = 0; i < int'(R1T) - 1; i++) script.push_back(8'hFF);
      script.push_back(8'h00);
      for (int i = 0; i < int'(TKT) - 1; i++) script.push_back(8'hFF);
      script.push_back(8'hFE);
      for (int i = 0; i < 514; i++) script.push_back(8'($urandom));
      build_expect(a);
      ready_mode = 2;
      start_op(a);
      checks++;
      if ({error, err_code} !== 3'b000) begin errors++; $display("FAIL rread_clear: got %b/%0d required 0/0", error, err_code); end
      wait_done(40000, 2000, to, e, c, b);
      ready_mode = 0;
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL rread_timeout: got timeout required done"); end
      checks++;
      if (log_diffs() !== 0) begin errors++; $display("FAIL rread_log: got %0d diffs required 0", log_diffs()); end
      checks++;
      if (data_diffs() !== 0) begin errors++; $display("FAIL rread_data: got %0d diffs (%0d bytes) required 0", data_diffs(), rx_q.size()); end
      checks++;
      if ({e, c} !== 3'b000 || done_cnt !== 1 || viol_total() !== 0) begin errors++; $display("FAIL rread_done: got %b/%0d pulses %0d viol %0d required 0/0/1/0", e, c, done_cnt, viol_total()); end
   endtask

   task automatic test_wait_ready_and_abort();
      bit to; logic e, b; logic [1:0] c; int unsigned n;
      script.delete();
      script = '{8'h00, 8'hFE};
      for (int i = 0; i < 514; i++) script.push_back(8'($urandom));
      spi_ready = 1'b0;
      start_op(32'h0000_4000);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b required 1", busy); end
      repeat (100) @(negedge clk);
      checks++;
      if (log_q.size() !== 0) begin errors++; $display("FAIL wr_early: got %0d strobes before ready required 0", log_q.size()); end
      spi_ready = 1'b1;
      to = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (log_q.size() > 0) begin to = 1'b0; break; end
      end
      checks++;
      if (to || log_q[0][10:8] !== 3'd4) begin errors++; $display("FAIL wr_first: got addr %0d (timeout %b) required 4", log_q[0][10:8], to); end
      to = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (rx_q.size() >= 40) begin to = 1'b0; break; end
      end
      checks++;
      if (to) begin errors++; $display("FAIL abort_reach_data: got %0d bytes required 40", rx_q.size()); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, error, out_valid, spi_enable, err_code, out_data, spi_addr, spi_din} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: got %h required 0",
                  {busy, done, error, out_valid, spi_enable, err_code, out_data, spi_addr, spi_din});
      end
      reset = 1'b0;
      n = log_q.size();
      repeat (30) @(negedge clk);
      checks++;
      if (done_cnt !== 0 || busy !== 1'b0 || log_q.size() !== n) begin errors++; $display("FAIL abort_idle: got done %0d busy %b strobes %0d required 0/0/%0d", done_cnt, busy, log_q.size(), n); end
      build_expect(32'h0000_4000);
      start_op(32'h0000_4000);
      wait_done(30000, -1, to, e, c, b);
      checks++;
      if (to !== 1'b0 || {e, c} !== 3'b000) begin errors++; $display("FAIL rerun_done: got timeout %b err %b/%0d required 0/0/0", to, e, c); end
      checks++;
      if (log_diffs() !== 0 || data_diffs() !== 0) begin errors++; $display("FAIL rerun_stream: got %0d log / %0d data diffs required 0/0", log_diffs(), data_diffs()); end
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_backpressure();
      test_r1_timeout();
      test_r1_error();
      test_bad_token();
      test_token_timeout();
      test_random_fail();
      test_random_read();
      test_wait_ready_and_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
